// File: rtl/morse_tx_sequencer_if.sv
// Character handshake between the Morse character source and the key-line sequencer.
interface morse_tx_sequencer_if;
   logic       sym_valid;
   logic [2:0] sym_len;
   logic [4:0] sym_bits;
   logic       sym_ready;

   modport master (output sym_valid, sym_len, sym_bits, input sym_ready);
   modport slave  (input sym_valid, sym_len, sym_bits, output sym_ready);
endinterface

// File: rtl/morse_tx_sequencer.sv
// Morse key-line sequencer: plays one character as dots/dashes with inter-element,
// inter-character and word gaps, all paced by ce ticks and a per-character unit length.
module morse_tx_sequencer #(
   parameter int unsigned UNIT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ce,
   input  logic                 enable,
   input  logic [UNIT_W-1:0]    unit_ticks,
   morse_tx_sequencer_if.slave  sym,
   output logic                 key_out,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, MARK, GAP, LGAP} state_t;

   state_t            state, state_n;
   logic [UNIT_W-1:0] tick, tick_n, ut, ut_n, ut_in;
   logic [2:0]        units, units_n, idx, idx_n, len, len_n, idx_next;
   logic [4:0]        bits, bits_n;
   logic              key_n, busy_n, done_n;
   logic              accept, phase_end;

   // Gated by rst_n so the handshake also reads 0 while reset is held.
   assign sym.sym_ready = rst_n && enable && (state == IDLE);
   assign accept        = sym.sym_valid && sym.sym_ready;
   assign ut_in         = (unit_ticks == '0) ? UNIT_W'(1) : unit_ticks;
   assign phase_end     = ce && (tick == '0) && (units == '0);
   assign idx_next      = idx + 3'd1;

   always_comb begin
      state_n = state;
      tick_n  = tick;
      units_n = units;
      idx_n   = idx;
      len_n   = len;
      bits_n  = bits;
      ut_n    = ut;
      done_n  = 1'b0;
      if (state != IDLE && !enable) begin
         state_n = IDLE;
      end else if (state == IDLE) begin
         if (accept) begin
            bits_n = sym.sym_bits;
            len_n  = (sym.sym_len > 3'd5) ? 3'd5 : sym.sym_len;
            ut_n   = ut_in;
            tick_n = ut_in - UNIT_W'(1);
            idx_n  = '0;
            if (sym.sym_len == '0) begin
               state_n = LGAP;
               units_n = 3'd6;
            end else begin
               state_n = MARK;
               units_n = sym.sym_bits[0] ? 3'd2 : 3'd0;
            end
         end
      end else if (phase_end) begin
         tick_n = ut - UNIT_W'(1);
         case (state)
            MARK: begin
               if (idx_next < len) begin
                  state_n = GAP;
                  units_n = 3'd0;
               end else begin
                  state_n = LGAP;
                  units_n = 3'd2;
               end
            end
            GAP: begin
               state_n = MARK;
               idx_n   = idx_next;
               units_n = bits[idx_next] ? 3'd2 : 3'd0;
            end
            LGAP: begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
            default: ;
         endcase
      end else if (ce) begin
         if (tick == '0) begin
            units_n = units - 3'd1;
            tick_n  = ut - UNIT_W'(1);
         end else begin
            tick_n = tick - UNIT_W'(1);
         end
      end
      key_n  = (state_n == MARK);
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tick    <= '0;
         units   <= '0;
         idx     <= '0;
         len     <= '0;
         bits    <= '0;
         ut      <= '0;
         key_out <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         tick    <= tick_n;
         units   <= units_n;
         idx     <= idx_n;
         len     <= len_n;
         bits    <= bits_n;
         ut      <= ut_n;
         key_out <= key_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Directed bench for morse_tx_sequencer: per-cycle traces of key/busy/done/ready
// are captured after each acceptance and compared against hand-derived bit patterns.
module tb_morse_tx_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce;
   logic        enable;
   logic [15:0] unit_ticks;
   logic        key_out, busy, done;
   int          total = 0;
   int          bad = 0;
   logic [31:0] rk, rb, rd, rr;

   morse_tx_sequencer_if sym ();

   morse_tx_sequencer #(.UNIT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .enable     (enable),
      .unit_ticks (unit_ticks),
      .sym        (sym),
      .key_out    (key_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Presents a character so it is accepted on the next rising edge.
   task automatic start(input logic [2:0] l, input logic [4:0] b, input logic [15:0] u,
                        input logic c);
      @(negedge clk);
      sym.sym_len   = l;
      sym.sym_bits  = b;
      sym.sym_valid = 1'b1;
      unit_ticks    = u;
      ce            = c;
   endtask

   // Bit i of each trace holds the output during cycle i+1 after the accepting edge.
   // unit_ticks is scrambled right after acceptance; the latched value must prevail.
   task automatic record(input int n, input int ce_mod, input logic hold);
      rk = '0; rb = '0; rd = '0; rr = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rk[i] = key_out;
         rb[i] = busy;
         rd[i] = done;
         rr[i] = sym.sym_ready;
         if (i == 0) begin
            if (!hold) sym.sym_valid = 1'b0;
            unit_ticks = ~unit_ticks;
         end
         ce = ((i + 1) % ce_mod) == 0;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; enable = 1'b1; ce = 1'b1; unit_ticks = 16'd1;
      sym.sym_valid = 1'b0; sym.sym_len = '0; sym.sym_bits = '0;
      #12;
      total++; if (sym.sym_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", sym.sym_ready); end
      total++; if (key_out !== 1'b0) begin bad++; $display("FAIL reset_key got %b want 0", key_out); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (sym.sym_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got %b want 1", sym.sym_ready); end
   endtask

   task automatic test_char_a;
      start(3'd2, 5'b00010, 16'd2, 1'b1);
      record(17, 1, 1'b0);
      total++; if (rk[16:0] !== 17'h003F3) begin bad++; $display("FAIL a_key got %h want %h", rk[16:0], 17'h003F3); end
      total++; if (rb[16:0] !== 17'h0FFFF) begin bad++; $display("FAIL a_busy got %h want %h", rb[16:0], 17'h0FFFF); end
      total++; if (rd[16:0] !== 17'h10000) begin bad++; $display("FAIL a_done got %h want %h", rd[16:0], 17'h10000); end
      total++; if (rr[16:0] !== 17'h10000) begin bad++; $display("FAIL a_ready got %h want %h", rr[16:0], 17'h10000); end
   endtask

   task automatic test_ce_div;
      start(3'd1, 5'b00000, 16'd1, 1'b0);
      record(17, 4, 1'b0);
      total++; if (rk[16:0] !== 17'h0000F) begin bad++; $display("FAIL cediv_key got %h want %h", rk[16:0], 17'h0000F); end
      total++; if (rb[16:0] !== 17'h0FFFF) begin bad++; $display("FAIL cediv_busy got %h want %h", rb[16:0], 17'h0FFFF); end
      total++; if (rd[16:0] !== 17'h10000) begin bad++; $display("FAIL cediv_done got %h want %h", rd[16:0], 17'h10000); end
   endtask

   task automatic test_word_space;
      start(3'd0, 5'b11111, 16'd3, 1'b1);
      record(22, 1, 1'b0);
      total++; if (rk[21:0] !== 22'h000000) begin bad++; $display("FAIL ws_key got %h want %h", rk[21:0], 22'h000000); end
      total++; if (rb[21:0] !== 22'h1FFFFF) begin bad++; $display("FAIL ws_busy got %h want %h", rb[21:0], 22'h1FFFFF); end
      total++; if (rd[21:0] !== 22'h200000) begin bad++; $display("FAIL ws_done got %h want %h", rd[21:0], 22'h200000); end
   endtask

   task automatic test_abort;
      start(3'd1, 5'b00001, 16'd2, 1'b1);
      rk = '0; rb = '0; rd = '0; rr = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rk[i] = key_out;
         rb[i] = busy;
         rd[i] = done;
         rr[i] = sym.sym_ready;
         if (i == 0) sym.sym_valid = 1'b0;
         if (i == 2) enable = 1'b0;
         if (i == 4) sym.sym_valid = 1'b1;
      end
      total++; if (rk[9:0] !== 10'h007) begin bad++; $display("FAIL abort_key got %h want %h", rk[9:0], 10'h007); end
      total++; if (rb[9:0] !== 10'h007) begin bad++; $display("FAIL abort_busy got %h want %h", rb[9:0], 10'h007); end
      total++; if (rd[9:0] !== 10'h000) begin bad++; $display("FAIL abort_done got %h want %h", rd[9:0], 10'h000); end
      total++; if (rr[9:0] !== 10'h000) begin bad++; $display("FAIL abort_ready got %h want %h", rr[9:0], 10'h000); end
      sym.sym_valid = 1'b0;
      enable = 1'b1;
      #1;
      total++; if (sym.sym_ready !== 1'b1) begin bad++; $display("FAIL abort_reenable got %b want 1", sym.sym_ready); end
   endtask

   task automatic test_clamp;
      start(3'd7, 5'b11111, 16'd0, 1'b1);
      record(23, 1, 1'b0);
      total++; if (rk[22:0] !== 23'h077777) begin bad++; $display("FAIL clamp_key got %h want %h", rk[22:0], 23'h077777); end
      total++; if (rb[22:0] !== 23'h3FFFFF) begin bad++; $display("FAIL clamp_busy got %h want %h", rb[22:0], 23'h3FFFFF); end
      total++; if (rd[22:0] !== 23'h400000) begin bad++; $display("FAIL clamp_done got %h want %h", rd[22:0], 23'h400000); end
   endtask

   task automatic test_back_to_back;
      start(3'd1, 5'b00000, 16'd1, 1'b1);
      record(6, 1, 1'b1);
      total++; if (rk[5:0] !== 6'h21) begin bad++; $display("FAIL b2b_key got %h want %h", rk[5:0], 6'h21); end
      total++; if (rd[5:0] !== 6'h10) begin bad++; $display("FAIL b2b_done got %h want %h", rd[5:0], 6'h10); end
      total++; if (rb[5:0] !== 6'h2F) begin bad++; $display("FAIL b2b_busy got %h want %h", rb[5:0], 6'h2F); end
      rst_n = 1'b0;
      #1;
      total++; if (key_out !== 1'b0) begin bad++; $display("FAIL arst_key got %b want 0", key_out); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL arst_done got %b want 0", done); end
      total++; if (sym.sym_ready !== 1'b0) begin bad++; $display("FAIL arst_ready got %b want 0", sym.sym_ready); end
      sym.sym_valid = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_char_a();
      test_ce_div();
      test_word_space();
      test_abort();
      test_clamp();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
